// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, rdata
// field positions and small row/column encode helpers.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_e;

   localparam int CODE_LSB  = 0;
   localparam int VALID_BIT = 4;
   localparam int OVF_BIT   = 5;

   localparam logic [3:0] ROW_RESET = 4'b1110;

   // When several columns read low, the lowest-numbered one is taken.
   function automatic logic [1:0] lowest_low(input logic [3:0] col);
      logic [1:0] idx;
      idx = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (!col[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   function automatic logic [1:0] row_index(input logic [3:0] row);
      logic [1:0] idx;
      case (row)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// CPU-side keyboard window: address-decode qualifier, read strobe, read data
// and key-available interrupt.
interface keypad_scanner_if;

   logic        kb_en;
   logic        kb_ren;
   logic [31:0] rdata;
   logic        irq;

   modport master (
      output kb_en,
      output kb_ren,
      input  rdata,
      input  irq
   );

   modport slave (
      input  kb_en,
      input  kb_ren,
      output rdata,
      output irq
   );

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous keypad column inputs; resets to
// all-high so an idle keypad is seen during and right after reset.
module keypad_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d_i,
   output logic [3:0] q_o
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge value of its source; blocking here would collapse the two stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 4'hF;
         sync_q <= 4'hF;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a single key
// register. Define KEYPAD_IRQ_EN to drive irq from the valid flag.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 25000,
   parameter int DEBOUNCE_CNT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        col_i,
   output logic [3:0]        row_o,
   keypad_scanner_if.slave   bus
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT);

   logic [3:0]       col_s;
   logic             any_low;
   logic [1:0]       low_idx;
   logic             tick;
   logic             latch;
   logic             rd_hit;

   state_e           state_q,    state_d;
   logic [DIV_W-1:0] div_q,      div_d;
   logic [3:0]       row_q,      row_d;
   logic [1:0]       cand_col_q, cand_col_d;
   logic [DEB_W-1:0] deb_cnt_q,  deb_cnt_d;
   logic [DEB_W-1:0] rel_cnt_q,  rel_cnt_d;
   logic [DEB_W-1:0] deb_inc;
   logic [DEB_W-1:0] rel_inc;
   logic [3:0]       code_q,     code_d;
   logic             valid_q,    valid_d;
   logic             ovf_q,      ovf_d;
   logic [31:0]      rdata_w;

   keypad_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (col_i),
      .q_o   (col_s)
   );

   assign any_low = ~&col_s;
   assign low_idx = lowest_low(col_s);
   assign tick    = (div_q == DIV_LAST);
   assign div_d   = tick ? '0 : div_q + DIV_W'(1);
   assign rd_hit  = bus.kb_en & bus.kb_ren;
   assign deb_inc = deb_cnt_q + DEB_W'(1);
   assign rel_inc = rel_cnt_q + DEB_W'(1);

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the case/if tree can leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      cand_col_d = cand_col_q;
      deb_cnt_d  = deb_cnt_q;
      rel_cnt_d  = rel_cnt_q;
      latch      = 1'b0;

      if (tick) begin
         unique case (state_q)
            SCAN: begin
               if (any_low) begin
                  cand_col_d = low_idx;
                  deb_cnt_d  = DEB_W'(1);
                  if (DEBOUNCE_CNT <= 1) begin
                     latch     = 1'b1;
                     rel_cnt_d = '0;
                     state_d   = HELD;
                  end else begin
                     state_d   = DEBOUNCE;
                  end
               end else begin
                  row_d = {row_q[2:0], row_q[3]};
               end
            end

            // An aborted candidate leaves the frozen row on this same tick,
            // just as an idle SCAN tick would.
            DEBOUNCE: begin
               if (any_low && (low_idx == cand_col_q)) begin
                  deb_cnt_d = deb_inc;
                  if (deb_inc == DEB_LAST) begin
                     latch     = 1'b1;
                     rel_cnt_d = '0;
                     state_d   = HELD;
                  end
               end else begin
                  deb_cnt_d = '0;
                  row_d     = {row_q[2:0], row_q[3]};
                  state_d   = SCAN;
               end
            end

            HELD: begin
               if (any_low) begin
                  rel_cnt_d = '0;
               end else if (rel_inc == DEB_LAST) begin
                  rel_cnt_d = '0;
                  deb_cnt_d = '0;
                  state_d   = SCAN;
               end else begin
                  rel_cnt_d = rel_inc;
               end
            end

            default: state_d = SCAN;
         endcase
      end
   end

   // A key latched in the same cycle as a consuming read wins over the read.
   always_comb begin
      code_d  = code_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      if (latch) begin
         code_d  = {row_index(row_q), cand_col_d};
         ovf_d   = valid_q & ~rd_hit;
         valid_d = 1'b1;
      end else if (rd_hit) begin
         valid_d = 1'b0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SCAN;
         div_q      <= '0;
         row_q      <= ROW_RESET;
         cand_col_q <= '0;
         deb_cnt_q  <= '0;
         rel_cnt_q  <= '0;
         code_q     <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         row_q      <= row_d;
         cand_col_q <= cand_col_d;
         deb_cnt_q  <= deb_cnt_d;
         rel_cnt_q  <= rel_cnt_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      rdata_w = '0;
      if (bus.kb_en) begin
         rdata_w[CODE_LSB +: 4] = code_q;
         rdata_w[VALID_BIT]     = valid_q;
         rdata_w[OVF_BIT]       = ovf_q;
      end
   end

   assign bus.rdata = rdata_w;
   assign row_o     = row_q;

`ifdef KEYPAD_IRQ_EN
   assign bus.irq = valid_q;
`else
   assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3; key presses
// are aligned to observed row changes so latch cycles are predictable.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] col_i = 4'hF;
   logic [3:0] row_o;

   int vectors     = 0;
   int miscompares = 0;

   keypad_scanner_if bus ();

   keypad_scanner #(
      .SCAN_DIV     (4),
      .DEBOUNCE_CNT (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .col_i (col_i),
      .row_o (row_o),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic exp_irq(input logic valid);
`ifdef KEYPAD_IRQ_EN
      return valid;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] row_pat(input int r);
      logic [3:0] one;
      one = 4'b0001 << r;
      return ~one;
   endfunction

   // Returns at the first falling edge after row_o switches to target.
   task automatic wait_row(input logic [3:0] target, input string name);
      int n;
      n = 0;
      while (row_o === target && n < 64) begin
         @(negedge clk);
         n++;
      end
      while (row_o !== target && n < 64) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (row_o !== target) begin
         miscompares++;
         $display("FAIL %s: row_o timed out at %b, waiting for %b", name, row_o, target);
      end
   endtask

   // Press a key as its row becomes active; latch lands 12 clocks later.
   task automatic press_key(input int r, input int c, input logic [31:0] exp_before,
                            input logic [31:0] exp_after, input bit read_at_latch,
                            input string name);
      logic [3:0] one;
      wait_row(row_pat(r), name);
      one   = 4'b0001 << c;
      col_i = ~one;
      repeat (11) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.rdata !== exp_before) begin
         miscompares++;
         $display("FAIL %s_pre: rdata %h, expected %h", name, bus.rdata, exp_before);
      end
      vectors++;
      if (bus.irq !== exp_irq(exp_before[4])) begin
         miscompares++;
         $display("FAIL %s_pre_irq: irq %b, expected %b", name, bus.irq, exp_irq(exp_before[4]));
      end
      if (read_at_latch) bus.kb_ren = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.kb_ren = 1'b0;
      #1;
      vectors++;
      if (bus.rdata !== exp_after) begin
         miscompares++;
         $display("FAIL %s_latch: rdata %h, expected %h", name, bus.rdata, exp_after);
      end
      vectors++;
      if (bus.irq !== exp_irq(exp_after[4])) begin
         miscompares++;
         $display("FAIL %s_latch_irq: irq %b, expected %b", name, bus.irq, exp_irq(exp_after[4]));
      end
   endtask

   task automatic release_key();
      col_i = 4'hF;
      repeat (24) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [3:0] exp_rows [3];
      exp_rows = '{4'b1011, 4'b0111, 4'b1110};
      rst_n      = 1'b0;
      bus.kb_en  = 1'b1;
      bus.kb_ren = 1'b0;
      col_i      = 4'hF;
      repeat (3) @(negedge clk);
      vectors++;
      if (row_o !== 4'b1110) begin
         miscompares++;
         $display("FAIL reset_row: row_o %b, expected 1110", row_o);
      end
      vectors++;
      if (bus.rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_rdata: rdata %h, expected 00000000", bus.rdata);
      end
      vectors++;
      if (bus.irq !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_irq: irq %b, expected 0", bus.irq);
      end
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (row_o !== 4'b1110) begin
         miscompares++;
         $display("FAIL rot_hold: row_o %b, expected 1110", row_o);
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (row_o !== 4'b1101) begin
         miscompares++;
         $display("FAIL rot_1: row_o %b, expected 1101", row_o);
      end
      for (int i = 0; i < 3; i++) begin
         repeat (4) @(posedge clk);
         @(negedge clk);
         vectors++;
         if (row_o !== exp_rows[i]) begin
            miscompares++;
            $display("FAIL rot_%0d: row_o %b, expected %b", i + 2, row_o, exp_rows[i]);
         end
      end
   endtask

   task automatic test_press();
      press_key(2, 2, 32'h0000_0000, 32'h0000_001A, 1'b0, "press_r2c2");
      repeat (8) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (row_o !== 4'b1011) begin
         miscompares++;
         $display("FAIL held_row: row_o %b, expected 1011", row_o);
      end
      vectors++;
      if (bus.rdata !== 32'h0000_001A) begin
         miscompares++;
         $display("FAIL held_rdata: rdata %h, expected 0000001a", bus.rdata);
      end
   endtask

   task automatic test_overflow_read();
      release_key();
      press_key(1, 1, 32'h0000_001A, 32'h0000_0035, 1'b0, "ovf_r1c1");
      bus.kb_en  = 1'b0;
      bus.kb_ren = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL unsel_rdata: rdata %h, expected 00000000", bus.rdata);
      end
      bus.kb_ren = 1'b0;
      bus.kb_en  = 1'b1;
      #1;
      vectors++;
      if (bus.rdata !== 32'h0000_0035) begin
         miscompares++;
         $display("FAIL unsel_ignored: rdata %h, expected 00000035", bus.rdata);
      end
      bus.kb_ren = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.kb_ren = 1'b0;
      #1;
      vectors++;
      if (bus.rdata !== 32'h0000_0005) begin
         miscompares++;
         $display("FAIL read_clear: rdata %h, expected 00000005", bus.rdata);
      end
      vectors++;
      if (bus.irq !== 1'b0) begin
         miscompares++;
         $display("FAIL read_irq: irq %b, expected 0", bus.irq);
      end
      release_key();
   endtask

   task automatic test_bounce();
      wait_row(4'b0111, "bounce_sync");
      col_i = 4'b1110;
      repeat (4) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (row_o !== 4'b0111) begin
         miscompares++;
         $display("FAIL bounce_freeze: row_o %b, expected 0111", row_o);
      end
      col_i = 4'hF;
      repeat (4) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (row_o !== 4'b1110) begin
         miscompares++;
         $display("FAIL bounce_resume: row_o %b, expected 1110", row_o);
      end
      vectors++;
      if (bus.rdata !== 32'h0000_0005) begin
         miscompares++;
         $display("FAIL bounce_rdata: rdata %h, expected 00000005", bus.rdata);
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (row_o !== 4'b1101) begin
         miscompares++;
         $display("FAIL bounce_rotate: row_o %b, expected 1101", row_o);
      end
   endtask

   task automatic test_read_latch_collision();
      press_key(3, 1, 32'h0000_0005, 32'h0000_001D, 1'b0, "press_r3c1");
      release_key();
      press_key(0, 2, 32'h0000_001D, 32'h0000_0012, 1'b1, "collide_r0c2");
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.rdata !== 32'h0000_0012) begin
         miscompares++;
         $display("FAIL collide_hold: rdata %h, expected 00000012", bus.rdata);
      end
   endtask

   task automatic test_reset_mid_debounce();
      release_key();
      wait_row(4'b1011, "mid_sync");
      col_i = 4'b0111;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if (row_o !== 4'b1110) begin
         miscompares++;
         $display("FAIL mid_reset_row: row_o %b, expected 1110", row_o);
      end
      vectors++;
      if (bus.rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL mid_reset_rdata: rdata %h, expected 00000000", bus.rdata);
      end
      vectors++;
      if (bus.irq !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_irq: irq %b, expected 0", bus.irq);
      end
      col_i = 4'hF;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (16) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (row_o !== 4'b1110 || bus.rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL post_reset: row_o %b rdata %h, expected 1110 and 00000000", row_o, bus.rdata);
      end
   endtask

   initial begin
      bus.kb_en  = 1'b1;
      bus.kb_ren = 1'b0;
      test_reset();
      test_press();
      test_overflow_read();
      test_bounce();
      test_read_latch_collision();
      test_reset_mid_debounce();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
